// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: operation codes, bus sizes, FSM states
// and the bundle handed to the writeback pipeline register.
package memory_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        MSIZE_BYTE = 2'd0,
        MSIZE_HALF = 2'd1,
        MSIZE_WORD = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } memory_data_t;

    function automatic logic is_load(mem_op_t op);
        logic r;
        r = (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
            (op == MEM_LHU) || (op == MEM_LW);
        return r;
    endfunction

    function automatic logic is_store(mem_op_t op);
        logic r;
        r = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
        return r;
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four.
    function automatic logic is_aligned(mem_op_t op, logic [1:0] lo);
        logic r;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: r = (lo[0] == 1'b0);
            MEM_LW, MEM_SW:          r = (lo == 2'b00);
            default:                 r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// SRAM-like data bus between the memory stage (master) and the data memory (slave).
interface memory_access_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  addr_ok;
    logic                  data_ok;
    logic [31:0]           rdata;

    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/memory_access_align.sv
// Byte-lane steering: store data replication/strobes and load extract/extend.
// Purely combinational so the uncached path can reuse it unchanged.
module mem_align
    import memory_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output msize_t      size_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Replicate store data into every lane and enable only the addressed bytes.
    always_comb begin
        wdata_o = store_data_i;
        wstrb_o = 4'b0000;
        case (op_i)
            MEM_SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                wstrb_o = 4'b0001 << lane_i;
            end
            MEM_SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                wstrb_o = lane_i[1] ? 4'b1100 : 4'b0011;
            end
            MEM_SW: begin
                wstrb_o = 4'b1111;
            end
            default: begin
            end
        endcase
    end

    // Access width presented on the bus.
    always_comb begin
        case (op_i)
            MEM_LB, MEM_LBU, MEM_SB: size_o = MSIZE_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: size_o = MSIZE_HALF;
            default:                 size_o = MSIZE_WORD;
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        case (lane_i)
            2'd0:    load_byte = rdata_i[7:0];
            2'd1:    load_byte = rdata_i[15:8];
            2'd2:    load_byte = rdata_i[23:16];
            default: load_byte = rdata_i[31:24];
        endcase
        load_half = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            MEM_LB:  load_data_o = {{24{load_byte[7]}}, load_byte};
            MEM_LBU: load_data_o = {24'd0, load_byte};
            MEM_LH:  load_data_o = {{16{load_half[15]}}, load_half};
            MEM_LHU: load_data_o = {16'd0, load_half};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: issues loads/stores on the data bus, stalls the
// pipeline until the response returns, and raises AdEL/AdES on misalignment.
module memory_access
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter bit DROP_ON_FLUSH = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  mem_op_t               memop_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            dest_i,
    input  logic                  flush_i,
    memory_access_if.master       bus,
    output logic                  valid_o,
    output logic [31:0]           result_o,
    output logic [4:0]            dest_o,
    output logic                  exc_adel_o,
    output logic                  exc_ades_o,
    output logic [ADDR_WIDTH-1:0] badvaddr_o,
    output logic                  stall_o
);

    mem_state_t            state_q, state_d;
    logic                  drop_q, drop_d;
    mem_op_t               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            dest_q;
    logic [31:0]           rdata_q;

    logic                  accept;
    logic                  capture;
    memory_data_t          wb;

    logic [31:0]           align_wdata;
    logic [3:0]            align_wstrb;
    msize_t                align_size;
    logic [31:0]           align_load;

    mem_align u_align (
        .op_i         (op_q),
        .lane_i       (addr_q[1:0]),
        .store_data_i (wdata_q),
        .rdata_i      (rdata_q),
        .wdata_o      (align_wdata),
        .wstrb_o      (align_wstrb),
        .size_o       (align_size),
        .load_data_o  (align_load)
    );

    // State, drop flag and the latched access; response data captured on data_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            dest_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (accept) begin
                op_q    <= memop_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                dest_q  <= dest_i;
            end
            if (capture) begin
                rdata_q <= bus.rdata;
            end
        end
    end

    // Next-state logic plus the writeback bundle and stall for the current state.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        accept  = 1'b0;
        capture = 1'b0;
        wb      = '0;
        valid_o = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    if (memop_i == MEM_NONE) begin
                        valid_o   = 1'b1;
                        wb.result = 32'(addr_i);
                        wb.dest   = dest_i;
                    end else if (!is_aligned(memop_i, addr_i[1:0])) begin
                        valid_o     = 1'b1;
                        wb.adel     = is_load(memop_i);
                        wb.ades     = is_store(memop_i);
                        wb.badvaddr = 32'(addr_i);
                    end else begin
                        accept  = 1'b1;
                        stall_o = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (flush_i && DROP_ON_FLUSH) begin
                    drop_d = 1'b1;
                end
                if (bus.addr_ok) begin
                    if (bus.data_ok) begin
                        capture = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (flush_i && DROP_ON_FLUSH) begin
                    drop_d = 1'b1;
                end
                if (bus.data_ok) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
                if (!drop_q) begin
                    valid_o = 1'b1;
                    if (is_load(op_q)) begin
                        wb.result = align_load;
                        wb.dest   = dest_q;
                    end else begin
                        wb.result = 32'(addr_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req   = (state_q == REQ);
    assign bus.wr    = is_store(op_q);
    assign bus.size  = align_size;
    assign bus.addr  = addr_q;
    assign bus.wdata = align_wdata;
    assign bus.wstrb = align_wstrb;

    assign result_o   = wb.result;
    assign dest_o     = wb.dest;
    assign exc_adel_o = wb.adel;
    assign exc_ades_o = wb.ades;
    assign badvaddr_o = ADDR_WIDTH'(wb.badvaddr);

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage directly downstream of the execute stage. Consumes the execute result (ALU address, store data, destination register).
- Issues loads/stores on the sram-like data bus and stalls the pipeline until the response arrives.
- Aligns and extends load data; raises AdEL/AdES on misaligned accesses.
- Output feeds the writeback pipeline register.

Parameters:
ADDR_WIDTH, 32, bus address width; the low 2 bits select the byte lane.
DROP_ON_FLUSH, 1, if 1 a flushed in-flight access completes on the bus but its result is discarded.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
valid_i  in  1  execute result valid.
memop_i  in  4  mem_op_t: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
addr_i  in  ADDR_WIDTH  effective address (execute aluout).
wdata_i  in  32  store data (execute writedata, after forwarding).
dest_i  in  5  destination register.
flush_i  in  1  exception/ERET flush from cp0.
req  out  1  bus request.
wr  out  1  1 = store.
size  out  2  0 = byte, 1 = half, 2 = word.
addr  out  ADDR_WIDTH  bus address (unmodified addr_i).
wdata  out  32  store data replicated into lanes.
wstrb  out  4  byte enables.
addr_ok  in  1  request accepted.
data_ok  in  1  response valid.
rdata  in  32  read data.
valid_o  out  1  result valid for writeback.
result_o  out  32  load data aligned/extended, else addr_i passthrough.
dest_o  out  5  destination register (0 for stores/exceptions).
exc_adel_o  out  1  load misaligned.
exc_ades_o  out  1  store misaligned.
badvaddr_o  out  ADDR_WIDTH  faulting address.
stall_o  out  1  hold all earlier pipeline registers.

Behaviour:
- Reset (async): state IDLE, req=0, drop=0, valid_o=0, stall_o=0, exc_*=0, latched regs 0.
- Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0.
- IDLE, valid_i & memop NONE: combinational pass-through. valid_o=1, result_o=addr_i, stall_o=0.
- IDLE, misaligned access: valid_o=1, exc_adel_o/exc_ades_o=1, badvaddr_o=addr_i, dest_o=0, no bus request, stall_o=0.
- IDLE, aligned access & !flush_i:
  - Latch op, addr, wdata, dest, addr[1:0].
  - stall_o=1 combinationally; go to REQ.
  - valid_o=0 this cycle.
- REQ: req=1, with addr/wr/size/wdata/wstrb driven from the latches.
  - req stays high until addr_ok (it is never withdrawn, even on flush).
  - addr_ok & data_ok same cycle -> RESP, capture rdata.
  - addr_ok alone -> WAIT.
- WAIT: req=0. data_ok -> RESP, capture rdata.
- RESP:
  - If drop=0: valid_o=1, stall_o=0.
  - If drop=1: valid_o=0, stall_o=0.
  - Next state IDLE; drop cleared.
- Stall: stall_o=1 in REQ and WAIT. Minimum load/store latency is 3 cycles (IDLE accept -> REQ -> RESP) with zero-wait bus.
- Flush:
  - flush_i in IDLE blocks acceptance.
  - flush_i in REQ/WAIT sets drop (when DROP_ON_FLUSH=1); the transaction still completes.
  - Stores already in REQ are still written; the exception unit treats them as committed.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1] ? 1100 : 0011.
  - SW: wstrb=1111.
  - Loads: wstrb=0000.
- Load extraction: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]). LB/LH sign-extend; LBU/LHU zero-extend.
- Spurious data_ok in IDLE/REQ-without-addr_ok: ignored. Assertion in bench.
- Reset during REQ/WAIT: return to IDLE immediately; the bus is reset by the same signal.

Decomposition:
- Shared package (memory_pkg): mem_op_t enum, msize_t, mem_state_t {IDLE, REQ, WAIT, RESP}, memory_data_t struct (result, dest, exceptions, badvaddr) for the writeback register.
- One sub-module: mem_align (purely combinational). Store lane/strobe generation and load extract/extend, shared with a later uncached path.

Test Plan:
- LW addr 0x8000_0010, bus addr_ok after 2 cycles, data_ok after 1 more, rdata 0xDEAD_BEEF -> stall_o high 4 cycles, valid_o with result 0xDEADBEEF, dest preserved.
- LB addr ...03, rdata 0x80_12_34_56 -> result 0xFFFF_FF80. LBU same -> 0x0000_0080. LHU addr ...02 -> 0x0000_8012.
- SH addr ...02 data 0x0000_ABCD -> wdata 0xABCD_ABCD, wstrb 1100, size 1, wr 1.
- LW addr ...02 -> exc_adel_o=1, badvaddr ...02, req never asserted, stall_o 0. SH addr ...01 -> exc_ades_o=1.
- Zero-wait bus (addr_ok & data_ok same cycle as req) -> RESP next cycle, 3-cycle total latency.
- flush_i during WAIT -> req not re-raised, data_ok consumed, valid_o stays 0. Async reset mid-REQ -> req drops same cycle.
